// File: rtl/channel_mux_bank.sv
// Per-channel pulse-source router with enable/polarity and hitless reconfiguration.
// A pending configuration is applied once old and new sources are low, or after TIMEOUT cycles.
module channel_mux_bank #(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned N_SRC   = 4,
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [N_SRC-1:0]      i_src,
    input  logic                  i_cfg_load,
    input  logic [N_CH*SEL_W-1:0] i_sel,
    input  logic [N_CH-1:0]       i_enable,
    input  logic [N_CH-1:0]       i_invert,
    output logic [N_CH-1:0]       o_channel,
    output logic [N_CH-1:0]       o_pending,
    output logic [N_CH-1:0]       o_switched,
    output logic [N_CH-1:0]       o_timeout
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic {StRun, StPend} state_e;

    state_e             state    [N_CH];
    logic [SEL_W-1:0]   act_sel  [N_CH];
    logic [SEL_W-1:0]   pend_sel [N_CH];
    logic [SEL_W-1:0]   ld_sel   [N_CH];
    logic [CNT_W-1:0]   cnt      [N_CH];
    logic [N_CH-1:0]    act_en, act_inv, pend_en, pend_inv;
    logic [N_CH-1:0]    act_src, old_ok, new_ok, ld_same;

    // Selectors beyond the last source read as a constant low.
    function automatic logic src_of(input logic [SEL_W-1:0] sel, input logic [N_SRC-1:0] src);
        logic v;
        v = 1'b0;
        for (int s = 0; s < N_SRC; s++) begin
            if (sel == SEL_W'(s)) v = src[s];
        end
        return v;
    endfunction

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            ld_sel[k]  = i_sel[k*SEL_W +: SEL_W];
            act_src[k] = src_of(act_sel[k], i_src);
            old_ok[k]  = ~act_en[k] | ~act_src[k];
            new_ok[k]  = ~pend_en[k] | ~src_of(pend_sel[k], i_src);
            ld_same[k] = (ld_sel[k] == act_sel[k]) && (i_enable[k] == act_en[k]) &&
                         (i_invert[k] == act_inv[k]);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= '{default: StRun};
            act_sel    <= '{default: '0};
            pend_sel   <= '{default: '0};
            cnt        <= '{default: '0};
            act_en     <= '0;
            act_inv    <= '0;
            pend_en    <= '0;
            pend_inv   <= '0;
            o_channel  <= '0;
            o_pending  <= '0;
            o_switched <= '0;
            o_timeout  <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                o_channel[k]  <= (act_en[k] & act_src[k]) ^ act_inv[k];
                o_switched[k] <= 1'b0;
                o_timeout[k]  <= 1'b0;
                // A load always wins over a switch that would happen on the same edge.
                if (i_cfg_load) begin
                    pend_sel[k] <= ld_sel[k];
                    pend_en[k]  <= i_enable[k];
                    pend_inv[k] <= i_invert[k];
                    cnt[k]      <= '0;
                    if (ld_same[k]) begin
                        state[k]     <= StRun;
                        o_pending[k] <= 1'b0;
                    end else begin
                        state[k]     <= StPend;
                        o_pending[k] <= 1'b1;
                    end
                end else if (state[k] == StPend) begin
                    if ((old_ok[k] && new_ok[k]) || (cnt[k] == CNT_W'(TIMEOUT - 1))) begin
                        act_sel[k]    <= pend_sel[k];
                        act_en[k]     <= pend_en[k];
                        act_inv[k]    <= pend_inv[k];
                        state[k]      <= StRun;
                        o_pending[k]  <= 1'b0;
                        o_switched[k] <= 1'b1;
                        o_timeout[k]  <= ~(old_ok[k] & new_ok[k]);
                    end else begin
                        cnt[k] <= cnt[k] + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule
